dca_matrix_lsu_write_txn_gen: RTL

- Upstream neighbour of the matrix LSU write-request packer.
- Accepts one matrix LSU instruction and walks the matrix row by row.
- Splits each row into AXI INCR bursts and emits one transaction-info word per burst over a valid/ready handshake.
- Each transaction-info word is {is_dummy, is_last, alen, bitaddr}, the format the packer consumes.

---
 rtl/dca_lsu.sv | 20 ++
 rtl/dca_burst_len_calc.sv | 30 +++
 rtl/dca_matrix_lsu_write_txn_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dca_lsu.sv
// Shared definitions for the matrix LSU write path: FSM states, AXI page
// constants and the transaction-info field layout.
package dca_lsu;

  localparam int AXI_4K_BYTES = 4096;
  localparam int BW_PAGE_OFS  = 12;
  localparam int BW_ALEN      = 8;
  localparam int BW_BURST     = 9;

  // Transaction-info word, MSB first: {is_dummy, is_last, alen[BW_ALEN-1:0], bitaddr[BW_ADDR+2:0]}
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } gen_state_e;

  function automatic int bus_bytes(int bw_axi_data);
    return bw_axi_data / 8;
  endfunction

endpackage

// File: rtl/dca_burst_len_calc.sv
// Beats in the next burst: min(beats left in row, MAX_BURST, beats to 4 KB page end).
module dca_burst_len_calc
  import dca_lsu::*;
#(
  parameter int BW_BEATS  = 20,
  parameter int BUS_BYTES = 4,
  parameter int MAX_BURST = 16
) (
  input  logic [BW_BEATS-1:0]    beats_left,
  input  logic [BW_PAGE_OFS-1:0] page_ofs,
  output logic [BW_BURST-1:0]    beats
);

  localparam int BW_CMP = (BW_BEATS > BW_PAGE_OFS + 1) ? BW_BEATS : BW_PAGE_OFS + 1;

  logic [BW_CMP-1:0] left_w;
  logic [BW_CMP-1:0] to4k_w;
  logic [BW_CMP-1:0] min_w;

  always_comb begin
    left_w = BW_CMP'(beats_left);
    // Start addresses are bus aligned, so the division is exact.
    to4k_w = BW_CMP'((AXI_4K_BYTES - int'(page_ofs)) / BUS_BYTES);
    min_w  = left_w;
    if (BW_CMP'(MAX_BURST) < min_w) min_w = BW_CMP'(MAX_BURST);
    if (to4k_w < min_w) min_w = to4k_w;
    beats = BW_BURST'(min_w);
  end

endmodule

// File: rtl/dca_matrix_lsu_write_txn_gen.sv
// Walks a matrix LSU instruction row by row and emits one AXI INCR burst
// descriptor per transaction. Handshakes: a transfer happens on a rising edge where valid & ready.
module dca_matrix_lsu_write_txn_gen
  import dca_lsu::*;
#(
  parameter int BW_ADDR     = 32,
  parameter int BW_AXI_DATA = 32,
  parameter int ELEM_BYTES  = 4,
  parameter int BW_NUM      = 16,
  parameter int MAX_BURST   = 16
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  input  logic                 inst_is_write,
  input  logic [BW_ADDR-1:0]   inst_addr,
  input  logic [BW_ADDR-1:0]   inst_stride,
  input  logic [BW_NUM-1:0]    inst_num_row_m1,
  input  logic [BW_NUM-1:0]    inst_num_col_m1,
  output logic                 txn_valid,
  input  logic                 txn_ready,
  output logic [BW_ADDR+2:0]   txn_bitaddr,
  output logic [BW_ALEN-1:0]   txn_alen,
  output logic                 txn_is_last,
  output logic                 txn_is_dummy,
  output logic                 busy,
  output gen_state_e           dbg_state
);

  localparam int BUS_BYTES = bus_bytes(BW_AXI_DATA);
  localparam int BW_BEATS  = BW_NUM + $clog2(ELEM_BYTES) + 2;

  gen_state_e          state;
  logic [BW_ADDR-1:0]  cur_addr;
  logic [BW_ADDR-1:0]  row_addr;
  logic [BW_ADDR-1:0]  stride_q;
  logic [BW_NUM-1:0]   rows_left;
  logic [BW_BEATS-1:0] beats_left;
  logic [BW_BEATS-1:0] row_beats_q;
  logic                dummy_q;

  logic                inst_hs;
  logic                txn_hs;
  logic [BW_BEATS-1:0] row_beats_in;
  logic [BW_BURST-1:0] cur_beats;

  logic                load;
  logic                done;
  logic [BW_ADDR-1:0]  nxt_cur;
  logic [BW_ADDR-1:0]  nxt_row;
  logic [BW_NUM-1:0]   nxt_rows;
  logic [BW_BEATS-1:0] nxt_beats_left;
  logic                nxt_dummy;
  logic                nxt_last;
  logic [BW_BURST-1:0] nxt_beats;

  assign inst_ready = (state == ST_IDLE);
  assign busy       = (state == ST_GEN);
  assign dbg_state  = state;
  assign inst_hs    = inst_valid & inst_ready;
  assign txn_hs     = txn_valid & txn_ready;

  assign row_beats_in = ((BW_BEATS'(inst_num_col_m1) + BW_BEATS'(1)) * BW_BEATS'(ELEM_BYTES)
                         + BW_BEATS'(BUS_BYTES - 1)) / BW_BEATS'(BUS_BYTES);
  // The burst in flight is recovered from the registered ALEN.
  assign cur_beats = BW_BURST'(txn_alen) + BW_BURST'(1);

  // Next walker position; the burst descriptor is computed from it so the
  // outputs can be registered without an extra cycle of latency.
  always_comb begin
    load           = 1'b0;
    done           = 1'b0;
    nxt_cur        = cur_addr;
    nxt_row        = row_addr;
    nxt_rows       = rows_left;
    nxt_beats_left = beats_left;
    nxt_dummy      = dummy_q;
    if (state == ST_IDLE) begin
      if (inst_hs) begin
        load           = 1'b1;
        nxt_cur        = inst_addr;
        nxt_row        = inst_addr;
        nxt_rows       = inst_num_row_m1;
        nxt_beats_left = row_beats_in;
        nxt_dummy      = ~inst_is_write;
      end
    end else if (txn_hs) begin
      if (txn_is_last) begin
        done = 1'b1;
      end else if (BW_BEATS'(cur_beats) < beats_left) begin
        load           = 1'b1;
        nxt_cur        = cur_addr + BW_ADDR'(cur_beats) * BW_ADDR'(BUS_BYTES);
        nxt_beats_left = beats_left - BW_BEATS'(cur_beats);
      end else begin
        load           = 1'b1;
        nxt_row        = row_addr + stride_q;
        nxt_cur        = row_addr + stride_q;
        nxt_beats_left = row_beats_q;
        nxt_rows       = rows_left - BW_NUM'(1);
      end
    end
  end

  dca_burst_len_calc #(
    .BW_BEATS  (BW_BEATS),
    .BUS_BYTES (BUS_BYTES),
    .MAX_BURST (MAX_BURST)
  ) u_burst_len (
    .beats_left (nxt_beats_left),
    .page_ofs   (nxt_cur[BW_PAGE_OFS-1:0]),
    .beats      (nxt_beats)
  );

  assign nxt_last = (BW_BEATS'(nxt_beats) == nxt_beats_left) && (nxt_rows == '0);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      row_addr     <= '0;
      stride_q     <= '0;
      rows_left    <= '0;
      beats_left   <= '0;
      row_beats_q  <= '0;
      dummy_q      <= 1'b0;
      txn_valid    <= 1'b0;
      txn_bitaddr  <= '0;
      txn_alen     <= '0;
      txn_is_last  <= 1'b0;
      txn_is_dummy <= 1'b0;
    end else begin
      if (inst_hs) begin
        stride_q    <= inst_stride;
        row_beats_q <= row_beats_in;
        dummy_q     <= ~inst_is_write;
      end
      if (load) begin
        state        <= ST_GEN;
        cur_addr     <= nxt_cur;
        row_addr     <= nxt_row;
        rows_left    <= nxt_rows;
        beats_left   <= nxt_beats_left;
        txn_valid    <= 1'b1;
        txn_bitaddr  <= {nxt_cur, 3'b000};
        txn_alen     <= nxt_dummy ? '0 : BW_ALEN'(nxt_beats - BW_BURST'(1));
        txn_is_last  <= nxt_dummy | nxt_last;
        txn_is_dummy <= nxt_dummy;
      end else if (done) begin
        state        <= ST_IDLE;
        txn_valid    <= 1'b0;
        txn_bitaddr  <= '0;
        txn_alen     <= '0;
        txn_is_last  <= 1'b0;
        txn_is_dummy <= 1'b0;
      end
    end
  end

endmodule
